fetch_unit: RTL

- Instruction fetch stage directly upstream of execute; drives the PC and instruction word consumed by decode/execute.
- Issues single-outstanding requests on a valid/ready instruction-memory port and buffers responses in a small FIFO.
- Consumes execute's override/newpc redirect, flushing wrong-path words (including one in flight), and flags misaligned redirect targets as a sticky fault.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, prefetch FIFO, redirect/flush and sticky misaligned fault.
// Optional FETCH_BYPASS_EN forwards a completing word straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hlt,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    input  logic        override,
    input  logic [31:0] newpc,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {ST_FETCH, ST_FAULT} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     pc_reg;
    logic [31:0]     addr_reg;
    logic            valid_reg;
    logic            discard_reg;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     mem_insn [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic in_fetch, complete, redirect, misaligned, keep, fifo_empty;
    logic bypass, push, pop, launch, head_valid;

    assign in_fetch   = (state_reg == ST_FETCH);
    assign complete   = valid_reg & imem_ready;
    assign redirect   = override & ~hlt & in_fetch;
    assign misaligned = redirect & (newpc[1:0] != 2'b00);
    // A completing word is only useful if it is on the current path
    assign keep       = complete & ~discard_reg & in_fetch & ~redirect;
    assign fifo_empty = (count_reg == '0);
    assign head_valid = ~fifo_empty & in_fetch;

`ifdef FETCH_BYPASS_EN
    assign bypass = keep & fifo_empty & out_ready & ~hlt;
`else
    assign bypass = 1'b0;
`endif

    assign push   = keep & ~bypass;
    assign pop    = head_valid & out_ready & ~hlt & ~redirect;
    assign launch = in_fetch & ~hlt & ~valid_reg & (count_reg < CW'(DEPTH)) & ~redirect;

    assign imem_valid = valid_reg;
    assign imem_addr  = addr_reg;
    assign out_valid  = head_valid | bypass;
    assign out_insn   = bypass ? imem_rdata : mem_insn[rd_ptr_reg];
    assign out_pc     = bypass ? addr_reg   : mem_pc[rd_ptr_reg];
    assign fault      = (state_reg == ST_FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: if (misaligned) state_next = ST_FAULT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase
    end

    // Request port and PC; the request address is held separately so a redirect cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= RESET_PC;
            addr_reg    <= '0;
            valid_reg   <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            if (launch) begin
                valid_reg <= 1'b1;
                addr_reg  <= pc_reg;
            end else if (complete) begin
                valid_reg <= 1'b0;
            end

            if (redirect && valid_reg && !complete) begin
                discard_reg <= 1'b1;
            end else if (complete) begin
                discard_reg <= 1'b0;
            end

            if (redirect) begin
                pc_reg <= newpc;
            end else if (keep) begin
                pc_reg <= pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PW'(gi)) begin
                mem_insn[gi] <= imem_rdata;
                mem_pc[gi]   <= addr_reg;
            end
        end
    end

endmodule
